// File: rtl/ema_sched_pkg.sv
// Shared types and constants for the EMA channel scheduler.
package ema_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_UPD  = 2'd2
  } state_t;

  localparam int          FRAC_W        = 8;
  localparam logic [15:0] DEFAULT_ALPHA = 16'd64;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the channel after the last grant and
// returns a one-hot grant plus the binary index of the winner.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  localparam int CW = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [CW-1:0]     i_lastGrant,
  output logic [NUM_CH-1:0] o_grant,
  output logic [CW-1:0]     o_idx
);

  int   w_idx;
  logic w_found;

  // Walk the channels starting one past the last winner, wrapping around,
  // and grant the first one that is requesting.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      w_idx = (int'(i_lastGrant) + k) % NUM_CH;
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_idx          = CW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/ema_channel_scheduler.sv
// Multi-channel exponential moving average engine. Channels compete for a
// single shared multiply/update path through a round-robin arbiter; each
// accepted sample takes three cycles (accept, multiply, update).
module ema_channel_scheduler #(
  parameter int          NUM_CH        = 4,
  parameter logic [15:0] DEFAULT_ALPHA = ema_sched_pkg::DEFAULT_ALPHA,
  localparam int         CW            = $clog2(NUM_CH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CH-1:0]      in_valid,
  input  logic [NUM_CH-1:0][15:0] in_data,
  output logic [NUM_CH-1:0]      in_ready,
  input  logic                   cfg_we,
  input  logic                   cfg_clear,
  input  logic [CW-1:0]          cfg_ch,
  input  logic [15:0]            cfg_alpha,
  output logic                   out_valid,
  output logic [CW-1:0]          out_ch,
  output logic [15:0]            out_data,
  output logic                   busy
);

  import ema_sched_pkg::*;

  state_t                r_state;
  logic [15:0]           r_ema   [NUM_CH];
  logic [15:0]           r_alpha [NUM_CH];
  logic [NUM_CH-1:0]     r_init;
  logic [CW-1:0]         r_lastGrant;

  logic [15:0]           r_capSample;
  logic [CW-1:0]         r_capCh;
  logic [15:0]           r_capAlpha;
  logic [15:0]           r_capEma;
  logic                  r_capInit;
  logic signed [33:0]    r_product;

  logic [NUM_CH-1:0]     w_grant;
  logic [CW-1:0]         w_grantIdx;
  logic                  w_accept;
  logic                  w_cfgInRange;
  logic signed [16:0]    w_diff;
  logic signed [16:0]    w_alphaS;
  logic signed [33:0]    w_prodNext;
  logic signed [33:0]    w_shifted;
  logic [15:0]           w_emaNext;
  logic                  w_unusedProd;

  rr_arbiter #(
    .NUM_CH(NUM_CH)
  ) u_arbiter (
    .i_req      (in_valid),
    .i_lastGrant(r_lastGrant),
    .o_grant    (w_grant),
    .o_idx      (w_grantIdx)
  );

  assign w_accept     = (r_state == ST_IDLE) && !reset && (|w_grant);
  assign in_ready     = ((r_state == ST_IDLE) && !reset) ? w_grant : '0;
  assign busy         = (r_state != ST_IDLE);
  assign w_cfgInRange = (int'(cfg_ch) < NUM_CH);

  assign w_diff       = $signed({r_capSample[15], r_capSample}) - $signed({r_capEma[15], r_capEma});
  assign w_alphaS     = $signed({1'b0, r_capAlpha});
  assign w_prodNext   = 34'(w_diff) * 34'(w_alphaS);
  assign w_shifted    = r_product >>> FRAC_W;
  assign w_emaNext    = r_capInit ? (r_capEma + w_shifted[15:0]) : r_capSample;
  assign w_unusedProd = ^w_shifted[33:16];

  // Per-channel alpha registers, rewritable at any time; an in-flight
  // operation keeps the alpha it captured at acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_alpha[i] <= DEFAULT_ALPHA;
      end
    end else if (cfg_we && w_cfgInRange) begin
      r_alpha[cfg_ch] <= cfg_alpha;
    end
  end

  // Sequencer: capture on accept, multiply, then write back the new average
  // and pulse the result. A clear aimed at the channel being updated is
  // applied after the update so the channel ends uninitialised.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_ch      <= '0;
      r_lastGrant <= CW'(NUM_CH - 1);
      r_init      <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_ema[i] <= '0;
      end
      r_capSample <= '0;
      r_capCh     <= '0;
      r_capAlpha  <= '0;
      r_capEma    <= '0;
      r_capInit   <= 1'b0;
      r_product   <= '0;
    end else begin
      out_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_capSample <= in_data[w_grantIdx];
            r_capCh     <= w_grantIdx;
            r_capAlpha  <= r_alpha[w_grantIdx];
            r_capEma    <= r_ema[w_grantIdx];
            r_capInit   <= r_init[w_grantIdx];
            r_lastGrant <= w_grantIdx;
            r_state     <= ST_MUL;
          end
        end
        ST_MUL: begin
          r_product <= w_prodNext;
          r_state   <= ST_UPD;
        end
        ST_UPD: begin
          r_ema[r_capCh]  <= w_emaNext;
          r_init[r_capCh] <= 1'b1;
          out_data        <= w_emaNext;
          out_ch          <= r_capCh;
          out_valid       <= 1'b1;
          r_state         <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
      if (cfg_clear && w_cfgInRange) begin
        r_init[cfg_ch] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ema_channel_scheduler.sv
// Directed self-checking bench for ema_channel_scheduler.
module tb_ema_channel_scheduler;

  localparam int NUM_CH = 4;
  localparam int CW     = 2;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0][15:0] in_data;
  logic [NUM_CH-1:0]       in_ready;
  logic                    cfg_we;
  logic                    cfg_clear;
  logic [CW-1:0]           cfg_ch;
  logic [15:0]             cfg_alpha;
  logic                    out_valid;
  logic [CW-1:0]           out_ch;
  logic [15:0]             out_data;
  logic                    busy;

  int checks = 0;
  int errors = 0;

  ema_channel_scheduler #(
    .NUM_CH(NUM_CH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .cfg_we   (cfg_we),
    .cfg_clear(cfg_clear),
    .cfg_ch   (cfg_ch),
    .cfg_alpha(cfg_alpha),
    .out_valid(out_valid),
    .out_ch   (out_ch),
    .out_data (out_data),
    .busy     (busy)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfgWrite(input int ch, input logic [15:0] alpha);
    cfg_we    = 1'b1;
    cfg_ch    = CW'(ch);
    cfg_alpha = alpha;
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  task automatic cfgClear(input int ch);
    cfg_clear = 1'b1;
    cfg_ch    = CW'(ch);
    @(negedge clk);
    cfg_clear = 1'b0;
  endtask

  task automatic applyStimulus(input int ch, input logic [15:0] data,
                               input logic [15:0] expData, input bit clearInUpd);
    in_valid     = '0;
    in_valid[ch] = 1'b1;
    in_data[ch]  = data;
    #1;
    checkOutput("grant", 32'(in_ready), 32'(1 << ch));
    @(posedge clk);
    @(negedge clk);
    in_valid = '0;
    checkOutput("busyMul", 32'(busy), 32'd1);
    checkOutput("readyWhileBusy", 32'(in_ready), 32'd0);
    @(negedge clk);
    checkOutput("noEarlyValid", 32'(out_valid), 32'd0);
    if (clearInUpd) begin
      cfg_clear = 1'b1;
      cfg_ch    = CW'(ch);
    end
    @(negedge clk);
    cfg_clear = 1'b0;
    checkOutput("validPulse", 32'(out_valid), 32'd1);
    checkOutput("outCh", 32'(out_ch), 32'(ch));
    checkOutput("outData", 32'(out_data), 32'(expData));
    @(negedge clk);
    checkOutput("validDrop", 32'(out_valid), 32'd0);
    checkOutput("dataHold", 32'(out_data), 32'(expData));
  endtask

  logic [15:0] rrData [NUM_CH];

  initial begin
    reset     = 1'b1;
    in_valid  = '1;
    in_data   = '0;
    cfg_we    = 1'b0;
    cfg_clear = 1'b0;
    cfg_ch    = '0;
    cfg_alpha = '0;
    repeat (2) @(negedge clk);

    checkOutput("rstReady", 32'(in_ready), 32'd0);
    checkOutput("rstValid", 32'(out_valid), 32'd0);
    checkOutput("rstData", 32'(out_data), 32'd0);
    checkOutput("rstCh", 32'(out_ch), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    in_valid = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(0, 16'h0100, 16'h0100, 1'b0);
    applyStimulus(0, 16'h0200, 16'h0140, 1'b0);

    applyStimulus(2, 16'h0200, 16'h0200, 1'b0);
    applyStimulus(2, 16'h0100, 16'h01C0, 1'b0);

    cfgWrite(1, 16'h0100);
    applyStimulus(1, 16'h0000, 16'h0000, 1'b0);
    applyStimulus(1, 16'h0300, 16'h0300, 1'b0);
    cfgWrite(1, 16'h0000);
    applyStimulus(1, 16'h0055, 16'h0300, 1'b0);

    cfgClear(0);
    applyStimulus(0, 16'h0050, 16'h0050, 1'b0);

    applyStimulus(0, 16'h0080, 16'h005C, 1'b1);
    applyStimulus(0, 16'h0011, 16'h0011, 1'b0);

    in_valid    = '0;
    in_valid[0] = 1'b1;
    in_data[0]  = 16'h0123;
    @(posedge clk);
    @(negedge clk);
    in_valid = '0;
    checkOutput("midBusy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstValid", 32'(out_valid), 32'd0);
    checkOutput("midRstData", 32'(out_data), 32'd0);
    checkOutput("midRstCh", 32'(out_ch), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("abortNoValid", 32'(out_valid), 32'd0);
    end

    rrData[0]  = 16'h0123;
    rrData[1]  = 16'h0020;
    rrData[2]  = 16'h0030;
    rrData[3]  = 16'h0040;
    for (int i = 0; i < NUM_CH; i++) begin
      in_data[i] = rrData[i];
    end
    in_valid = '1;
    #1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        checkOutput("rrValid", 32'(out_valid), 32'd1);
        checkOutput("rrOutCh", 32'(out_ch), 32'((k - 1) % NUM_CH));
        checkOutput("rrOutData", 32'(out_data), 32'(rrData[(k - 1) % NUM_CH]));
      end
      checkOutput("rrGrant", 32'(in_ready), 32'(1 << (k % NUM_CH)));
      @(negedge clk);
      checkOutput("rrBusyMul", 32'(busy), 32'd1);
      checkOutput("rrReadyMul", 32'(in_ready), 32'd0);
      @(negedge clk);
      checkOutput("rrBusyUpd", 32'(busy), 32'd1);
      checkOutput("rrReadyUpd", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid = '0;
    checkOutput("rrLastValid", 32'(out_valid), 32'd1);
    checkOutput("rrLastCh", 32'(out_ch), 32'd0);
    checkOutput("rrLastData", 32'(out_data), 32'h0123);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
